// File: rtl/jtframe_rom_pkg.sv
`default_nettype none
//==============================================================================
// Package  : jtframe_rom_pkg
// Desc     : Shared types and constants for the ROM fetch arbiter:
//            FSM state encoding, SDRAM word-address width, fetch timeout limit.
// Revision : 1.0 - initial release
//==============================================================================
package jtframe_rom_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } rom_state_t;

  localparam int         SDRAM_AW    = 22;
  localparam logic [7:0] TIMEOUT_MAX = 8'd255;

endpackage
`default_nettype wire

// File: rtl/jtframe_rom_slot.sv
`default_nettype none
//==============================================================================
// Module   : jtframe_rom_slot
// Desc     : One-entry 32-bit cache slot for a single ROM channel. Holds the
//            tag of the last filled 32-bit word, reports hit/miss for the
//            current channel address and selects the addressed 16-bit half.
// Revision : 1.0 - initial release
//==============================================================================
module jtframe_rom_slot
  import jtframe_rom_pkg::*;
#(
  parameter int AW = 15
)(
  input  logic          clk,
  input  logic          abort,
  input  logic [AW-1:0] addr,
  input  logic          cs,
  input  logic          busy_here,
  input  logic          wr_en,
  input  logic [AW-2:0] wr_tag,
  input  logic [31:0]   wr_data,
  output logic          ok,
  output logic [15:0]   dout,
  output logic          miss
);

  logic [AW-2:0] r_tag;
  logic [31:0]   r_data;
  logic          r_valid;
  logic          w_hit;

  // Slot storage: cleared on abort, written when the arbiter fills this slot
  always_ff @(posedge clk) begin
    if (abort) begin
      r_tag   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (wr_en) begin
      r_tag   <= wr_tag;
      r_data  <= wr_data;
      r_valid <= 1'b1;
    end
  end

  assign w_hit = r_valid && (r_tag == addr[AW-1:1]);
  assign ok    = cs && w_hit;
  assign dout  = addr[0] ? r_data[31:16] : r_data[15:0];
  // A channel whose fetch is already in flight does not request again
  assign miss  = cs && !w_hit && !busy_here;

endmodule
`default_nettype wire

// File: rtl/jtframe_rom_arb.sv
`default_nettype none
//==============================================================================
// Module   : jtframe_rom_arb
// Desc     : NCH-channel ROM fetch arbiter in front of a single-port SDRAM
//            controller. Each channel has a one-entry cache slot; misses are
//            arbitrated (fixed priority or round-robin) into one outstanding
//            32-bit burst at a time, with a per-channel SDRAM base offset.
// Config   : define JTFRAME_ROM_TIMEOUT_EN to enable the WAIT-state fetch
//            timeout (sticky flag plus request retry).
// Revision : 1.0 - initial release
//==============================================================================
module jtframe_rom_arb
  import jtframe_rom_pkg::*;
#(
  parameter int                        NCH     = 2,
  parameter int                        AW      = 15,
  parameter logic [NCH*SDRAM_AW-1:0]   OFFSETS = '0,
  parameter int                        RR      = 0,
  parameter int                        RDY_DLY = 4
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH*AW-1:0]     ch_addr,
  input  logic [NCH-1:0]        ch_cs,
  output logic [NCH-1:0]        ch_ok,
  output logic [NCH*16-1:0]     ch_dout,
  input  logic                  downloading,
  input  logic                  loop_rst,
  input  logic                  sdram_ack,
  input  logic                  data_rdy,
  input  logic [31:0]           data_read,
  output logic                  sdram_req,
  output logic [SDRAM_AW-1:0]   sdram_addr,
  output logic                  refresh_en,
  output logic                  ready,
  output logic                  timeout
);

  localparam int SW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int RCW = $clog2(RDY_DLY + 1);

  logic                w_abort;
  rom_state_t          r_state, w_state_nxt;
  logic [SW-1:0]       r_sel, w_sel_nxt, r_ptr, w_ptr_nxt, w_win;
  logic [AW-2:0]       r_tag_req, w_tag_nxt;
  logic                r_req, w_req_nxt;
  logic [SDRAM_AW-1:0] r_addr, w_addr_nxt;
  logic                w_fill;
  logic [NCH-1:0]      w_miss;
  logic                w_any_miss;
  logic [RCW-1:0]      r_rdy_cnt;
`ifdef JTFRAME_ROM_TIMEOUT_EN
  logic [7:0]          r_tcnt, w_tcnt_nxt;
  logic                r_timeout, w_timeout_nxt;
`endif

  // Reset, controller loop reset and ROM download all flush the fetch path
  assign w_abort = !rst_n || loop_rst || downloading;

  // Winner among missing channels: highest index, or first after ptr for RR
  function automatic logic [SW-1:0] f_pick(input logic [NCH-1:0] miss,
                                           input logic [SW-1:0]  ptr);
    logic [SW-1:0] win;
    logic [SW-1:0] idx;
    logic          found;
    win   = '0;
    found = 1'b0;
    if (RR == 0) begin
      for (int i = 0; i < NCH; i++) begin
        if (miss[i]) win = SW'(i);
      end
    end else begin
      for (int k = 1; k <= NCH; k++) begin
        idx = SW'((int'(ptr) + k) % NCH);
        if (!found && miss[idx]) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

  for (genvar n = 0; n < NCH; n++) begin : g_slot
    logic w_busy_here;
    logic w_wr_en;
    assign w_busy_here = (r_state != ST_IDLE) && (r_sel == SW'(n));
    assign w_wr_en     = w_fill && (r_sel == SW'(n));
    jtframe_rom_slot #(.AW(AW)) u_slot (
      .clk       (clk),
      .abort     (w_abort),
      .addr      (ch_addr[n*AW +: AW]),
      .cs        (ch_cs[n]),
      .busy_here (w_busy_here),
      .wr_en     (w_wr_en),
      .wr_tag    (r_tag_req),
      .wr_data   (data_read),
      .ok        (ch_ok[n]),
      .dout      (ch_dout[n*16 +: 16]),
      .miss      (w_miss[n])
    );
  end

  assign w_any_miss = |w_miss;
  assign w_win      = f_pick(w_miss, r_ptr);

  // Next-state, request and fill decode
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_tag_nxt   = r_tag_req;
    w_req_nxt   = r_req;
    w_addr_nxt  = r_addr;
    w_fill      = 1'b0;
`ifdef JTFRAME_ROM_TIMEOUT_EN
    w_tcnt_nxt    = '0;
    w_timeout_nxt = r_timeout;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_any_miss) begin
          w_sel_nxt   = w_win;
          w_ptr_nxt   = w_win;
          w_tag_nxt   = ch_addr[int'(w_win)*AW + 1 +: AW-1];
          // Offset add wraps naturally at the SDRAM address width
          w_addr_nxt  = OFFSETS[int'(w_win)*SDRAM_AW +: SDRAM_AW]
                        + SDRAM_AW'({w_tag_nxt, 1'b0});
          w_req_nxt   = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (sdram_ack) begin
          w_req_nxt = 1'b0;
          // Data arriving with the ack completes the burst at once
          if (data_rdy) begin
            w_fill      = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (data_rdy) begin
          w_fill      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
`ifdef JTFRAME_ROM_TIMEOUT_EN
        else if (r_tcnt == TIMEOUT_MAX) begin
          w_timeout_nxt = 1'b1;
          w_req_nxt     = 1'b1;
          w_state_nxt   = ST_REQ;
        end else begin
          w_tcnt_nxt = r_tcnt + 8'd1;
        end
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state and latched request registers
  always_ff @(posedge clk) begin
    if (w_abort) begin
      r_state   <= ST_IDLE;
      r_sel     <= '0;
      r_ptr     <= '0;
      r_tag_req <= '0;
      r_req     <= 1'b0;
      r_addr    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_ptr     <= w_ptr_nxt;
      r_tag_req <= w_tag_nxt;
      r_req     <= w_req_nxt;
      r_addr    <= w_addr_nxt;
    end
  end

  // Ready delay: saturating count of clean cycles since the last abort
  always_ff @(posedge clk) begin
    if (w_abort) begin
      r_rdy_cnt <= '0;
    end else if (r_rdy_cnt != RCW'(RDY_DLY)) begin
      r_rdy_cnt <= r_rdy_cnt + 1'b1;
    end
  end

`ifdef JTFRAME_ROM_TIMEOUT_EN
  // WAIT-state watchdog and sticky timeout flag
  always_ff @(posedge clk) begin
    if (w_abort) begin
      r_tcnt    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_tcnt    <= w_tcnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end
  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  assign sdram_req  = r_req;
  assign sdram_addr = r_addr;
  assign refresh_en = (r_state == ST_IDLE) && !w_any_miss;
  assign ready      = (r_rdy_cnt == RCW'(RDY_DLY));

endmodule
`default_nettype wire

// File: tb/tb_jtframe_rom_arb.sv
`default_nettype none
//==============================================================================
// Module   : tb_jtframe_rom_arb
// Desc     : Self-checking bench for jtframe_rom_arb. Instance A: NCH=2, fixed
//            priority, ch1 offset 0x4000. Instance R: NCH=3, round-robin with
//            a wrapping ch2 offset. Both share the SDRAM response signals;
//            only one instance has chip selects active at a time.
// Revision : 1.0 - initial release
//==============================================================================
module tb_jtframe_rom_arb;

  logic        clk = 1'b0;
  logic        rst_n, downloading, loop_rst;
  logic        sdram_ack, data_rdy;
  logic [31:0] data_read;

  logic [29:0] a_addr;
  logic [1:0]  a_cs, a_ok;
  logic [31:0] a_dout;
  logic        a_req, a_ref, a_rdy, a_to;
  logic [21:0] a_saddr;

  logic [44:0] r_addr;
  logic [2:0]  r_cs, r_ok;
  logic [47:0] r_dout;
  logic        r_req, r_ref, r_rdy, r_to;
  logic [21:0] r_saddr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jtframe_rom_arb #(
    .NCH(2), .AW(15), .OFFSETS({22'h004000, 22'h000000}), .RR(0), .RDY_DLY(4)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .ch_addr(a_addr), .ch_cs(a_cs), .ch_ok(a_ok),
    .ch_dout(a_dout), .downloading(downloading), .loop_rst(loop_rst),
    .sdram_ack(sdram_ack), .data_rdy(data_rdy), .data_read(data_read),
    .sdram_req(a_req), .sdram_addr(a_saddr), .refresh_en(a_ref),
    .ready(a_rdy), .timeout(a_to)
  );

  jtframe_rom_arb #(
    .NCH(3), .AW(15), .OFFSETS({22'h3FFFF0, 22'h200000, 22'h100000}), .RR(1), .RDY_DLY(4)
  ) u_rr (
    .clk(clk), .rst_n(rst_n), .ch_addr(r_addr), .ch_cs(r_cs), .ch_ok(r_ok),
    .ch_dout(r_dout), .downloading(downloading), .loop_rst(loop_rst),
    .sdram_ack(sdram_ack), .data_rdy(data_rdy), .data_read(data_read),
    .sdram_req(r_req), .sdram_addr(r_saddr), .refresh_en(r_ref),
    .ready(r_rdy), .timeout(r_to)
  );

  typedef struct {
    logic [1:0]  cs;
    logic [14:0] a0, a1;
    logic        fetch;
    logic [21:0] eaddr;
    logic [31:0] data;
    logic [1:0]  eok;
    logic [15:0] ed0, ed1;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Wait (bounded) for the selected instance to request, then check its address
  task automatic wait_req(input int which, input logic [21:0] exp, input string nm);
    int n = 0;
    while (!(which == 1 ? r_req : a_req) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_req"},  {31'd0, (which == 1 ? r_req : a_req)}, 32'd1);
    chk({nm, "_addr"}, {10'd0, (which == 1 ? r_saddr : a_saddr)}, {10'd0, exp});
  endtask

  task automatic do_ack();
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
  endtask

  task automatic do_fill(input logic [31:0] d);
    data_rdy  = 1'b1;
    data_read = d;
    @(negedge clk);
    data_rdy  = 1'b0;
  endtask

  initial begin
    int            exp_ch[6];
    logic [14:0]   ra[3];
    logic [21:0]   roff[3];
    logic [21:0]   e;
    int            c;
    int            n;

    rst_n = 1'b0; downloading = 1'b0; loop_rst = 1'b0;
    sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
    a_addr = '0; a_cs = '0; r_addr = '0; r_cs = '0;

    //             cs     a0        a1        fetch eaddr       data          eok    ed0       ed1
    vecs[0] = '{2'b11, 15'h0011, 15'h0004, 1'b0, 22'h000000, 32'h0,        2'b11, 16'h1234, 16'hCAFE};
    vecs[1] = '{2'b01, 15'h0100, 15'h0004, 1'b1, 22'h000100, 32'hAAAA5555, 2'b01, 16'h5555, 16'hCAFE};
    vecs[2] = '{2'b10, 15'h0100, 15'h7FFF, 1'b1, 22'h00BFFE, 32'h01020304, 2'b10, 16'h5555, 16'h0102};
    vecs[3] = '{2'b00, 15'h0100, 15'h7FFF, 1'b0, 22'h000000, 32'h0,        2'b00, 16'h5555, 16'h0102};
    vecs[4] = '{2'b11, 15'h0101, 15'h7FFE, 1'b0, 22'h000000, 32'h0,        2'b11, 16'hAAAA, 16'h0304};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req",  {31'd0, a_req}, 32'd0);
    chk("rst_ready", {31'd0, a_rdy}, 32'd0);
    chk("rst_ok",   {30'd0, a_ok},  32'd0);
    chk("rst_to",   {31'd0, a_to},  32'd0);
    chk("rst_ref",  {31'd0, a_ref}, 32'd1);

    // Ready rises exactly RDY_DLY cycles after reset release
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rdy_early", {31'd0, a_rdy}, 32'd0);
    @(negedge clk);
    chk("rdy_on", {31'd0, a_rdy}, 32'd1);

    // Fixed-priority collision: ch1 first, then ch0
    a_cs = 2'b11;
    a_addr = {15'h0005, 15'h0010};
    wait_req(0, 22'h004004, "col1");
    do_ack();
    chk("col1_req_drop", {31'd0, a_req}, 32'd0);
    do_fill(32'hBEEF_CAFE);
    chk("col1_ok", {31'd0, a_ok[1]}, 32'd1);
    chk("col1_dout", {16'd0, a_dout[31:16]}, 32'h0000_BEEF);
    wait_req(0, 22'h000010, "col0");
    do_ack();
    do_fill(32'h1234_5678);
    chk("col0_ok", {30'd0, a_ok}, 32'd3);
    chk("col0_dout", {16'd0, a_dout[15:0]}, 32'h0000_5678);

    // Table-driven hit/miss vectors
    for (int i = 0; i < 5; i++) begin
      a_cs   = vecs[i].cs;
      a_addr = {vecs[i].a1, vecs[i].a0};
      #1;
      if (vecs[i].fetch) begin
        wait_req(0, vecs[i].eaddr, "vec");
        do_ack();
        do_fill(vecs[i].data);
      end
      chk("vec_ok",  {30'd0, a_ok},          {30'd0, vecs[i].eok});
      chk("vec_d0",  {16'd0, a_dout[15:0]},  {16'd0, vecs[i].ed0});
      chk("vec_d1",  {16'd0, a_dout[31:16]}, {16'd0, vecs[i].ed1});
      @(negedge clk);
    end

    // Address change while waiting for data: stale fill never hits
    a_cs = 2'b01;
    a_addr = {15'h7FFE, 15'h0020};
    wait_req(0, 22'h000020, "mid1");
    do_ack();
    a_addr = {15'h7FFE, 15'h0040};
    do_fill(32'h1111_2222);
    chk("mid_stale_ok", {31'd0, a_ok[0]}, 32'd0);
    wait_req(0, 22'h000040, "mid2");
    do_ack();
    do_fill(32'h3333_4444);
    chk("mid_ok", {31'd0, a_ok[0]}, 32'd1);
    chk("mid_dout", {16'd0, a_dout[15:0]}, 32'h0000_4444);

    // Refresh gating
    a_cs = 2'b00;
    #1;
    chk("ref_idle", {31'd0, a_ref}, 32'd1);
    a_cs = 2'b01;
    a_addr = {15'h7FFE, 15'h0300};
    #1;
    chk("ref_miss", {31'd0, a_ref}, 32'd0);
    wait_req(0, 22'h000300, "ref");
    chk("ref_req", {31'd0, a_ref}, 32'd0);
    do_ack();
    chk("ref_wait", {31'd0, a_ref}, 32'd0);
    do_fill(32'h5555_6666);
    chk("ref_hit", {31'd0, a_ref}, 32'd1);
    // Stray data in IDLE is ignored
    do_fill(32'hDEAD_DEAD);
    chk("stray_dout", {16'd0, a_dout[15:0]}, 32'h0000_6666);
    chk("stray_req", {31'd0, a_req}, 32'd0);

    // Round-robin: all channels missing, new address after each fill
    a_cs = 2'b00;
    exp_ch = '{1, 2, 0, 1, 2, 0};
    ra   = '{15'h0002, 15'h0004, 15'h0020};
    roff = '{22'h100000, 22'h200000, 22'h3FFFF0};
    r_addr = {ra[2], ra[1], ra[0]};
    r_cs = 3'b111;
    for (int g = 0; g < 6; g++) begin
      c = exp_ch[g];
      e = roff[c] + {7'd0, ra[c][14:1], 1'b0};
      wait_req(1, e, "rr");
      do_ack();
      do_fill({16'(g), 16'hA5A5});
      chk("rr_ok", {31'd0, r_ok[c]}, 32'd1);
      ra[c] = ra[c] + 15'h0010;
      r_addr = {ra[2], ra[1], ra[0]};
    end
    r_cs = 3'b000;

    // Abort during WAIT, then ready delay after downloading drops
    a_cs = 2'b01;
    a_addr = {15'h7FFE, 15'h0200};
    wait_req(0, 22'h000200, "abt");
    do_ack();
    downloading = 1'b1;
    @(negedge clk);
    chk("abt_req",   {31'd0, a_req}, 32'd0);
    chk("abt_ok",    {30'd0, a_ok},  32'd0);
    chk("abt_dout",  a_dout,         32'd0);
    chk("abt_ready", {31'd0, a_rdy}, 32'd0);
    chk("abt_rready", {31'd0, r_rdy}, 32'd0);
    a_cs = 2'b00;
    @(negedge clk);
    downloading = 1'b0;
    repeat (3) @(negedge clk);
    chk("abt_rdy_early", {31'd0, a_rdy}, 32'd0);
    @(negedge clk);
    chk("abt_rdy_on", {31'd0, a_rdy}, 32'd1);

    // Fetch timeout: withhold data_rdy after ack
    a_cs = 2'b01;
    a_addr = {15'h7FFE, 15'h0400};
    wait_req(0, 22'h000400, "to");
    do_ack();
    n = 0;
    while (!a_to && n < 300) begin
      @(negedge clk);
      n++;
    end
`ifdef JTFRAME_ROM_TIMEOUT_EN
    chk("to_flag", {31'd0, a_to}, 32'd1);
    chk("to_req",  {31'd0, a_req}, 32'd1);
    chk("to_addr", {10'd0, a_saddr}, 32'h0000_0400);
    do_ack();
    do_fill(32'h7777_8888);
    chk("to_sticky", {31'd0, a_to}, 32'd1);
`else
    chk("to_flag", {31'd0, a_to}, 32'd0);
    chk("to_req",  {31'd0, a_req}, 32'd0);
    do_fill(32'h7777_8888);
`endif
    chk("to_fill_ok", {31'd0, a_ok[0]}, 32'd1);
    chk("to_fill_dout", {16'd0, a_dout[15:0]}, 32'h0000_8888);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
